r_instr_encoder: RTL and testbench
==================================

# r_instr_encoder

Sequential R-type instruction encoder and loader: the inverse of the ALU control decode. It accepts a stream of ALU-operation requests (4-bit `ula_op` plus register indices) over a valid/ready handshake. It encodes each request into a 32-bit RV32I R-format word (opcode/funct3/funct7) and writes the words to consecutive instruction-memory addresses. It sits between the testbench or boot loader and the instruction memory of the single-cycle core, and generates programs that the core's decode path then turns back into the same `ula_op`.

## Interface
- `ADDR_W`, 32: width of the memory byte address.
- `BASE_ADDR`, 0: byte address of the first word written after `start`.
- `DEPTH`, 64: maximum number of words per load session.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: one-cycle pulse that begins a session; honoured only in IDLE, DONE or ERR.
- `req_valid` input 1: a request is present.
- `req_ready` output 1: block accepts a request; high exactly when state is ACCEPT.
- `req_ula_op` input 4: requested operation.
- `req_rd`, `req_rs1`, `req_rs2` input 5 each: register indices.
- `req_last` input 1: the accompanying request is the final word of the session.
- `mem_we` output 1: one-cycle write strobe per word.
- `mem_addr` output ADDR_W: byte address of the current write.
- `mem_wdata` output 32: encoded instruction.
- `busy` output 1: state is ACCEPT.
- `done` output 1: state is DONE (successful session).
- `err_invalid` output 1: sticky flag, set when an unsupported `ula_op` is received.
- `err_full` output 1: sticky flag, set on DEPTH overflow.
- `word_count` output $clog2(DEPTH+1): number of words written in the current session.

## Operation
- Encoding uses opcode 0110011. Word = {funct7, rs2, rs1, funct3, rd, opcode}.
- Supported `ula_op` values and their encodings:
  - `0010`: add, funct7 0000000, funct3 000.
  - `0110`: sub, funct7 0100000, funct3 000.
  - `0000`: and, funct7 0000000, funct3 111.
  - `0001`: or, funct7 0000000, funct3 110.
- Every other `ula_op` value is invalid.
- FSM states are IDLE, ACCEPT, DONE and ERR. Reset enters IDLE.
- IDLE, DONE, ERR, on `start`:
  - Go to ACCEPT.
  - Internal next-address becomes BASE_ADDR.
  - `word_count`, `err_invalid` and `err_full` are cleared.
- ACCEPT, on handshake (`req_valid` && `req_ready`) with a valid op:
  - Register `mem_we`=1, `mem_wdata`=encoding, `mem_addr`=next-address.
  - Next-address advances by 4; `word_count` increments.
  - Then, in priority order:
    - If `req_last`, go to DONE.
    - Else, if this was word number DEPTH, go to ERR with `err_full`=1 (the word is still written).
    - Otherwise stay in ACCEPT.
- ACCEPT, on handshake with an invalid op:
  - No write; `word_count` is unchanged.
  - `err_invalid`=1; go to ERR.
- `start` while in ACCEPT is ignored.
- DONE and ERR hold all flags and `word_count` until the next `start`.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.

## Timing
- Reset (asynchronous, any cycle, including mid-session): state IDLE; `mem_we`, `busy`, `done`, `err_invalid`, `err_full` = 0; `mem_addr`, `mem_wdata`, `word_count` = 0. Any in-flight word is dropped.
- `start` sampled at edge N gives ACCEPT from N; `req_ready`=1 in the following cycle.
- Write latency is 1: a handshake at edge k gives `mem_we`=1 with its data/address in the cycle after k.
- `mem_we` stays high only if another handshake occurs at edge k+1.
- Throughput is one word per cycle with `req_valid` held high.
- After a `req_last` handshake, `done`=1 and `req_ready`=0 in the same cycle as the final `mem_we` pulse.
- An ERR entry deasserts `req_ready` in the next cycle; requests presented afterwards are not accepted.
- `mem_addr`/`mem_wdata` hold their last values when `mem_we`=0.

## Test plan
- Reset then `start`; send add rd=3, rs1=1, rs2=2, last=1. Expect one `mem_we` at `mem_addr`=0 with `mem_wdata`=0x002081B3, then `done`=1 and `word_count`=1.
- Back-to-back stream with `req_valid` held high:
  - sub x5,x6,x7 gives 0x407302B3 at address 0.
  - and x10,x11,x12 gives 0x00C5F533 at address 4.
  - or x1,x2,x3 (last) gives 0x003160B3 at address 8.
  - Expect 3 consecutive `mem_we` cycles, `done`=1 and `word_count`=3.
- Send one valid word, then `ula_op`=0111. Expect no second write, `err_invalid`=1, state ERR, `req_ready`=0 and `word_count`=1.
- With DEPTH=4, send 4 words none marked last. Expect 4 writes at addresses 0..12, `err_full`=1 and `req_ready`=0 afterwards. A 5th request is not accepted.
- Assert `rst_n`=0 mid-stream after 2 words. Expect all outputs 0 immediately. A new `start` restarts at BASE_ADDR with `word_count`=0.
- Pulse `start` while in ACCEPT. Expect no effect on address or count. `start` after DONE clears `done` and the flags.

Source files
------------

// File: rtl/r_instr_encoder.sv
// r_instr_encoder: turns a stream of ALU-operation requests into RV32I R-type
// instruction words and writes them to consecutive instruction-memory
// addresses. Sessions start with `start` and end in DONE (last word
// written) or ERR (unsupported op or DEPTH overflow).
module r_instr_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       DEPTH     = 64,
  localparam int unsigned      CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_ula_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic              req_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_invalid,
  output logic              err_full,
  output logic [CNT_W-1:0]  word_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [6:0]       OPCODE_R = 7'b0110011;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_next_addr;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic [CNT_W-1:0]    r_word_count;
  logic                r_err_invalid;
  logic                r_err_full;

  logic                w_op_ok;
  logic [6:0]          w_funct7;
  logic [2:0]          w_funct3;
  logic [31:0]         w_word;
  logic                w_begin;
  logic                w_accept;
  logic                w_set_inv;
  logic                w_set_full;

  // Map the requested ALU operation onto its funct7/funct3 pair.
  always_comb begin
    w_op_ok  = 1'b1;
    w_funct7 = 7'b0000000;
    w_funct3 = 3'b000;
    case (req_ula_op)
      4'b0010: begin
        w_funct7 = 7'b0000000;
        w_funct3 = 3'b000;
      end
      4'b0110: begin
        w_funct7 = 7'b0100000;
        w_funct3 = 3'b000;
      end
      4'b0000: begin
        w_funct7 = 7'b0000000;
        w_funct3 = 3'b111;
      end
      4'b0001: begin
        w_funct7 = 7'b0000000;
        w_funct3 = 3'b110;
      end
      default: w_op_ok = 1'b0;
    endcase
  end

  assign w_word = {w_funct7, req_rs2, req_rs1, w_funct3, req_rd, OPCODE_R};

  // Next-state decision plus the one-cycle control strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_begin     = 1'b0;
    w_accept    = 1'b0;
    w_set_inv   = 1'b0;
    w_set_full  = 1'b0;
    case (r_state)
      S_ACCEPT: begin
        if (req_valid) begin
          if (w_op_ok) begin
            w_accept = 1'b1;
            // last takes priority over overflow: a final word at DEPTH is a clean finish
            if (req_last) begin
              w_state_nxt = S_DONE;
            end else if (r_word_count == LAST_CNT) begin
              w_state_nxt = S_ERR;
              w_set_full  = 1'b1;
            end
          end else begin
            w_state_nxt = S_ERR;
            w_set_inv   = 1'b1;
          end
        end
      end
      default: begin
        if (start) begin
          w_state_nxt = S_ACCEPT;
          w_begin     = 1'b1;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write port, address pointer, word counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_addr   <= '0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_word_count  <= '0;
      r_err_invalid <= 1'b0;
      r_err_full    <= 1'b0;
    end else begin
      r_mem_we <= w_accept;
      if (w_begin) begin
        r_next_addr   <= BASE_ADDR;
        r_word_count  <= '0;
        r_err_invalid <= 1'b0;
        r_err_full    <= 1'b0;
      end
      if (w_accept) begin
        r_mem_addr   <= r_next_addr;
        r_mem_wdata  <= w_word;
        r_next_addr  <= r_next_addr + ADDR_W'(4);
        r_word_count <= r_word_count + CNT_W'(1);
      end
      if (w_set_inv) begin
        r_err_invalid <= 1'b1;
      end
      if (w_set_full) begin
        r_err_full <= 1'b1;
      end
    end
  end

  assign req_ready   = (r_state == S_ACCEPT);
  assign busy        = (r_state == S_ACCEPT);
  assign done        = (r_state == S_DONE);
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign err_invalid = r_err_invalid;
  assign err_full    = r_err_full;
  assign word_count  = r_word_count;

endmodule

// File: tb/tb_r_instr_encoder.sv
// Bench for r_instr_encoder: encoding table, hand-written session sequences
// and a randomized run, all compared each cycle against a session-level model.
module tb_r_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_ula_op;
  logic [4:0]    req_rd;
  logic [4:0]    req_rs1;
  logic [4:0]    req_rs2;
  logic          req_last;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err_invalid;
  logic          err_full;
  logic [CW-1:0] word_count;

  r_instr_encoder #(
    .ADDR_W   (32),
    .BASE_ADDR(32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ula_op (req_ula_op),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_last   (req_last),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err_invalid(err_invalid),
    .err_full   (err_full),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Session-level reference state.
  logic        m_open;
  logic        m_done;
  logic        m_inv;
  logic        m_full;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic [31:0] m_next;
  int          m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  function automatic logic ref_op_ok(input logic [3:0] op);
    return (op == 4'd2) || (op == 4'd6) || (op == 4'd0) || (op == 4'd1);
  endfunction

  function automatic logic [31:0] ref_encode(input logic [3:0] op, input int rd, input int rs1,
                                             input int rs2);
    int f7;
    int f3;
    f7 = 0;
    f3 = 0;
    if (op == 4'd6) f7 = 32;
    if (op == 4'd0) f3 = 7;
    if (op == 4'd1) f3 = 6;
    return 32'(f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 51);
  endfunction

  task automatic model_reset();
    m_open  = 1'b0;
    m_done  = 1'b0;
    m_inv   = 1'b0;
    m_full  = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_next  = '0;
    m_count = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    m_we = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (m_open) begin
      if (req_valid) begin
        if (ref_op_ok(req_ula_op)) begin
          m_we    = 1'b1;
          m_addr  = m_next;
          m_data  = ref_encode(req_ula_op, int'(req_rd), int'(req_rs1), int'(req_rs2));
          m_next  = m_next + 32'd4;
          m_count = m_count + 1;
          if (req_last) begin
            m_open = 1'b0;
            m_done = 1'b1;
          end else if (m_count == DEPTH) begin
            m_open = 1'b0;
            m_full = 1'b1;
          end
        end else begin
          m_open = 1'b0;
          m_inv  = 1'b1;
        end
      end
    end else if (start) begin
      m_open  = 1'b1;
      m_done  = 1'b0;
      m_inv   = 1'b0;
      m_full  = 1'b0;
      m_count = 0;
      m_next  = 32'h0000_0000;
    end
  endtask

  task automatic check_all();
    chk("req_ready", 32'(req_ready), 32'(m_open));
    chk("busy", 32'(busy), 32'(m_open));
    chk("done", 32'(done), 32'(m_done));
    chk("err_invalid", 32'(err_invalid), 32'(m_inv));
    chk("err_full", 32'(err_full), 32'(m_full));
    chk("word_count", 32'(word_count), 32'(m_count));
    chk("mem_we", 32'(mem_we), 32'(m_we));
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_data);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    start     = 1'b0;
    req_valid = 1'b0;
    req_last  = 1'b0;
  endtask

  task automatic do_start();
    quiet();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Presents a request for one edge; req_valid stays high for back-to-back use.
  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic last);
    req_valid  = 1'b1;
    req_ula_op = op;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_last   = last;
    step();
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ok;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{op: 4'b0010, rd: 5'd3,  rs1: 5'd1,  rs2: 5'd2,  ok: 1'b1, word: 32'h002081B3};
    vecs[1] = '{op: 4'b0110, rd: 5'd5,  rs1: 5'd6,  rs2: 5'd7,  ok: 1'b1, word: 32'h407302B3};
    vecs[2] = '{op: 4'b0000, rd: 5'd10, rs1: 5'd11, rs2: 5'd12, ok: 1'b1, word: 32'h00C5F533};
    vecs[3] = '{op: 4'b0001, rd: 5'd1,  rs1: 5'd2,  rs2: 5'd3,  ok: 1'b1, word: 32'h003160B3};
    vecs[4] = '{op: 4'b0010, rd: 5'd31, rs1: 5'd31, rs2: 5'd31, ok: 1'b1, word: 32'h01FF8FB3};
    vecs[5] = '{op: 4'b0110, rd: 5'd0,  rs1: 5'd31, rs2: 5'd0,  ok: 1'b1, word: 32'h400F8033};
    vecs[6] = '{op: 4'b0111, rd: 5'd4,  rs1: 5'd4,  rs2: 5'd4,  ok: 1'b0, word: 32'h0};
    vecs[7] = '{op: 4'b1111, rd: 5'd9,  rs1: 5'd8,  rs2: 5'd7,  ok: 1'b0, word: 32'h0};

    rst_n      = 1'b1;
    start      = 1'b0;
    req_valid  = 1'b0;
    req_ula_op = '0;
    req_rd     = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    req_last   = 1'b0;
    model_reset();

    // Reset state
    #2 rst_n = 1'b0;
    #1 check_all();
    step();
    rst_n = 1'b1;
    step();

    // Encoding table, one single-word session per vector
    for (int i = 0; i < 8; i++) begin
      do_start();
      send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, 1'b1);
      quiet();
      chk("vec_we", 32'(mem_we), 32'(vecs[i].ok));
      if (vecs[i].ok) begin
        chk("vec_wdata", mem_wdata, vecs[i].word);
        chk("vec_addr", mem_addr, 32'h0);
        chk("vec_done", 32'(done), 32'd1);
        chk("vec_count", 32'(word_count), 32'd1);
      end else begin
        chk("vec_err_invalid", 32'(err_invalid), 32'd1);
        chk("vec_count_inv", 32'(word_count), 32'd0);
      end
      step();
    end

    // Back-to-back stream of three words
    do_start();
    send(4'b0110, 5'd5, 5'd6, 5'd7, 1'b0);
    chk("stream0_we", 32'(mem_we), 32'd1);
    chk("stream0_data", mem_wdata, 32'h407302B3);
    chk("stream0_addr", mem_addr, 32'h0);
    send(4'b0000, 5'd10, 5'd11, 5'd12, 1'b0);
    chk("stream1_we", 32'(mem_we), 32'd1);
    chk("stream1_data", mem_wdata, 32'h00C5F533);
    chk("stream1_addr", mem_addr, 32'h4);
    send(4'b0001, 5'd1, 5'd2, 5'd3, 1'b1);
    chk("stream2_we", 32'(mem_we), 32'd1);
    chk("stream2_data", mem_wdata, 32'h003160B3);
    chk("stream2_addr", mem_addr, 32'h8);
    chk("stream_done", 32'(done), 32'd1);
    chk("stream_ready", 32'(req_ready), 32'd0);
    chk("stream_count", 32'(word_count), 32'd3);
    step();
    chk("stream_we_off", 32'(mem_we), 32'd0);
    quiet();

    // One valid word then an unsupported op
    do_start();
    send(4'b0010, 5'd3, 5'd1, 5'd2, 1'b0);
    send(4'b0111, 5'd3, 5'd1, 5'd2, 1'b0);
    chk("inv_we", 32'(mem_we), 32'd0);
    chk("inv_flag", 32'(err_invalid), 32'd1);
    chk("inv_ready", 32'(req_ready), 32'd0);
    chk("inv_count", 32'(word_count), 32'd1);
    chk("inv_done", 32'(done), 32'd0);
    quiet();
    step();

    // DEPTH overflow: four words without last, then a rejected fifth
    do_start();
    for (int i = 0; i < 4; i++) begin
      send(4'b0010, 5'(i + 1), 5'd1, 5'd2, 1'b0);
      chk("full_we", 32'(mem_we), 32'd1);
      chk("full_addr", mem_addr, 32'(i * 4));
    end
    chk("full_flag", 32'(err_full), 32'd1);
    chk("full_ready", 32'(req_ready), 32'd0);
    send(4'b0010, 5'd9, 5'd1, 5'd2, 1'b0);
    chk("full_5th_we", 32'(mem_we), 32'd0);
    chk("full_5th_count", 32'(word_count), 32'd4);
    quiet();
    step();

    // Asynchronous reset mid-stream
    do_start();
    send(4'b0010, 5'd3, 5'd1, 5'd2, 1'b0);
    send(4'b0001, 5'd4, 5'd1, 5'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_count", 32'(word_count), 32'd0);
    quiet();
    step();
    rst_n = 1'b1;
    do_start();
    chk("rst_restart_count", 32'(word_count), 32'd0);
    send(4'b0110, 5'd5, 5'd6, 5'd7, 1'b1);
    chk("rst_restart_addr", mem_addr, 32'h0);
    quiet();
    step();

    // start during ACCEPT is ignored; start after DONE clears status
    do_start();
    send(4'b0010, 5'd3, 5'd1, 5'd2, 1'b0);
    start = 1'b1;
    send(4'b0110, 5'd5, 5'd6, 5'd7, 1'b0);
    start = 1'b0;
    chk("mid_start_addr", mem_addr, 32'h4);
    chk("mid_start_count", 32'(word_count), 32'd2);
    send(4'b0001, 5'd1, 5'd2, 5'd3, 1'b1);
    chk("mid_start_done", 32'(done), 32'd1);
    do_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_count", 32'(word_count), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    quiet();
    step();

    // Randomized traffic, including occasional resets
    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      int pick;
      pick = int'($urandom_range(0, 4));
      if (pick == 4) op = 4'($urandom);
      else if (pick == 0) op = 4'b0010;
      else if (pick == 1) op = 4'b0110;
      else if (pick == 2) op = 4'b0000;
      else op = 4'b0001;
      start      = ($urandom_range(0, 5) == 0);
      req_valid  = ($urandom_range(0, 3) != 0);
      req_ula_op = op;
      req_rd     = 5'($urandom);
      req_rs1    = 5'($urandom);
      req_rs2    = 5'($urandom);
      req_last   = ($urandom_range(0, 4) == 0);
      rst_n      = ($urandom_range(0, 79) != 0);
      step();
    end
    rst_n = 1'b1;
    quiet();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
